nonce_dispatcher: RTL
=====================

NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 Parameter NUM_CORES, default 4, number of hash cores served; legal range 2..8.
REQ-002 clock  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse; begins a job; ignored unless state is IDLE.
REQ-005 abort  in  1  level; stops issuing new nonces while high; ignored in IDLE.
REQ-006 nonce_start  in  32  first nonce of the job; sampled on accepted start.
REQ-007 nonce_end  in  32  last nonce of the job, inclusive; sampled on accepted start.
REQ-008 core_ready  in  NUM_CORES  bit i high: core i is idle and can accept a nonce.
REQ-009 core_issue  out  NUM_CORES  one-hot, one-cycle pulse; assigns core_nonce to core i.
REQ-010 core_nonce  out  32  nonce assigned; valid only in a cycle with core_issue nonzero.
REQ-011 core_done  in  NUM_CORES  bit i pulse: core i has finished its assigned nonce.
REQ-012 core_found  in  NUM_CORES  bit i qualified by core_done[i]; hash met target.
REQ-013 core_result  in  32*NUM_CORES  slice i is the nonce core i finished; qualified by core_done[i].
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 job_done  out  1  one-cycle pulse when a job ends.
REQ-016 found  out  1  high: last job ended with a hit; held until the next accepted start.
REQ-017 found_nonce  out  32  winning nonce; held until the next accepted start.
REQ-018 state  out  2  IDLE=00, DISPATCH=01, DRAIN=10, FINISH=11.

Function
REQ-019 IDLE: on start, load next_nonce<=nonce_start, last<=nonce_end, and clear found, found_nonce and pending; go to DISPATCH.
REQ-020 DISPATCH: in each cycle, issue to at most one core, chosen round-robin.
REQ-021 Round-robin: the search begins at the index after the last issued core, wraps NUM_CORES-1 to 0, and selects the first core with core_ready=1 and pending=0.
REQ-022 Issue cycle: core_issue[i]=1, core_nonce=next_nonce, pending[i] set, next_nonce<=next_nonce+1 mod 2^32.
REQ-023 The dispatcher detects the end of the range only by equality (issued nonce == last), never by overflow, so that ranges crossing 0xFFFFFFFF->0 and the full 2^32 range are legal.
REQ-024 Issuing the nonce equal to last sends the FSM to DRAIN in the next cycle.
REQ-025 Any core_done[i] clears pending[i], including a core_done in the same cycle as an issue to another core.
REQ-026 core_done[i] while pending[i]=0 is ignored: no state change.
REQ-027 A hit is core_done[i]&core_found[i] while pending[i]=1, seen in DISPATCH or DRAIN.
REQ-028 On a hit, set found=1 and found_nonce=core_result slice i.
REQ-029 If several cores report a hit in the same cycle, the lowest index wins.
REQ-030 After the first hit, later hits never overwrite found_nonce.
REQ-031 A hit or abort=1 in DISPATCH stops issuing in that same cycle (core_issue=0) and sends the FSM to DRAIN.
REQ-032 DRAIN: no issues; wait until pending==0, then go to FINISH; if pending is already 0 on entry, leave after one cycle.
REQ-033 FINISH: pulse job_done for one cycle, then go to IDLE; start is ignored in FINISH.
REQ-034 Latency: first core_issue at the earliest 1 cycle after the accepted start; the dispatcher issues at most one nonce per clock.
REQ-035 A start asserted while busy=1 has no effect.

Reset
REQ-036 reset=0 at any clock edge forces the following values, regardless of the current state:
- state=IDLE
- core_issue=0, core_nonce=0
- pending=0, round-robin pointer=NUM_CORES-1, next_nonce=0, last=0
- busy=0, job_done=0, found=0, found_nonce=0
REQ-037 A reset in the middle of a job abandons the job and does not pulse job_done.
REQ-038 The dispatcher issues nothing in the first cycle after reset is released.

Verification
REQ-039 NUM_CORES=4, all ready, start, range 0x10..0x17, cores never hit -> issues go to cores 0,1,2,3,0,... with nonces 0x10..0x17; then one job_done pulse with found=0.
REQ-040 Range 0xFFFFFFFE..0x00000001 -> the four nonces issued are FFFFFFFE, FFFFFFFF, 00000000, 00000001; job ends with found=0.
REQ-041 Cores 1 and 3 report a hit in the same cycle, with core_result 0x55 and 0x99 -> found_nonce=0x55; issuing stops in that cycle; job_done follows once every pending core reports done.
REQ-042 Only core 2 is ready -> every issue goes to core 2, and each new issue waits for core 2's done.
REQ-043 abort raised after 3 issues -> no further issues; job_done after the outstanding dones; found=0.
REQ-044 reset=0 in DRAIN with pending cores -> the next cycle shows IDLE with every output at its reset value and no job_done; stray core_done pulses afterwards are ignored.

Source files
------------

// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: hands out a nonce range to hash cores round-robin,
// captures the first hit and drains outstanding work before finishing.
module nonce_dispatcher #(
  parameter int NUM_CORES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             nonce_start,
  input  logic [31:0]             nonce_end,
  input  logic [NUM_CORES-1:0]    core_ready,
  output logic [NUM_CORES-1:0]    core_issue,
  output logic [31:0]             core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [32*NUM_CORES-1:0] core_result,
  output logic                    busy,
  output logic                    job_done,
  output logic                    found,
  output logic [31:0]             found_nonce,
  output logic [1:0]              state
);

  localparam int PW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPATCH = 2'b01,
    DRAIN    = 2'b10,
    FINISH   = 2'b11
  } state_t;

  state_t cur;
  state_t nxt;

  logic [NUM_CORES-1:0] pending;
  logic [PW-1:0]        ptr;
  logic [31:0]          next_nonce;
  logic [31:0]          last;

  logic                 sel_vld;
  logic [PW-1:0]        sel_idx;
  logic [PW-1:0]        try_idx;
  logic                 hit;
  logic [31:0]          hit_res;
  logic                 accept;
  logic                 issue;

  // Search starts just after the last issued core and wraps.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    try_idx = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      try_idx = PW'((int'(ptr) + k) % NUM_CORES);
      if (!sel_vld && core_ready[try_idx] && !pending[try_idx]) begin
        sel_vld = 1'b1;
        sel_idx = try_idx;
      end
    end
  end

  // Descending scan so the lowest reporting index wins.
  always_comb begin
    hit     = 1'b0;
    hit_res = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_done[i] && core_found[i] && pending[i]) begin
        hit     = 1'b1;
        hit_res = core_result[32*i +: 32];
      end
    end
  end

  assign accept = (cur == IDLE) && start;
  assign issue  = (cur == DISPATCH) && !hit && !abort && sel_vld;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE: begin
        if (start) nxt = DISPATCH;
      end
      DISPATCH: begin
        if (hit || abort) begin
          nxt = DRAIN;
        end else if (issue && (next_nonce == last)) begin
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pending == '0) nxt = FINISH;
      end
      FINISH: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    core_issue = '0;
    core_nonce = '0;
    if (issue) begin
      core_issue = NUM_CORES'(1) << sel_idx;
      core_nonce = next_nonce;
    end
    busy     = (cur != IDLE);
    job_done = (cur == FINISH);
    state    = cur;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending     <= '0;
      ptr         <= PW'(NUM_CORES - 1);
      next_nonce  <= '0;
      last        <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
    end else if (accept) begin
      pending     <= '0;
      next_nonce  <= nonce_start;
      last        <= nonce_end;
      found       <= 1'b0;
      found_nonce <= '0;
    end else begin
      pending <= (pending & ~core_done) | core_issue;
      if (issue) begin
        next_nonce <= next_nonce + 32'd1;
        ptr        <= sel_idx;
      end
      if (hit && !found && (cur == DISPATCH || cur == DRAIN)) begin
        found       <= 1'b1;
        found_nonce <= hit_res;
      end
    end
  end

endmodule
